// File: rtl/alien_hit_detect_if.sv
// Signal bundle between the game core and the alien-row collision front end.
// master drives the projectile/row inputs; slave (the detector) drives hit, proj_kill and busy.
interface alien_hit_detect_if #(
   parameter int NUM_ALIENS = 7
);
   logic                  frame_tick;
   logic [2:0]            curr_state;
   logic                  proj_active;
   logic [9:0]            proj_x;
   logic [9:0]            proj_y;
   logic [9:0]            row_x;
   logic [9:0]            row_y;
   logic [NUM_ALIENS-1:0] row_alive;
   logic [NUM_ALIENS-1:0] hit;
   logic                  proj_kill;
   logic                  busy;

   modport master (
      output frame_tick, curr_state, proj_active, proj_x, proj_y, row_x, row_y, row_alive,
      input  hit, proj_kill, busy
   );

   modport slave (
      input  frame_tick, curr_state, proj_active, proj_x, proj_y, row_x, row_y, row_alive,
      output hit, proj_kill, busy
   );
endinterface

// File: rtl/alien_hit_detect.sv
// Per-frame projectile vs. alien-row collision scan, one column per cycle, one-hot hit output.
// Optional hit counter output hit_count is built when ALIEN_HIT_CNT_EN is defined.
module alien_hit_detect #(
   parameter int NUM_ALIENS  = 7,
   parameter int SHAPE_W     = 21,
   parameter int SHAPE_H     = 16,
   parameter int SHAPE_SPACE = 9,
   parameter int HIT_HOLD    = 2,
   parameter int COOLDOWN    = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   alien_hit_detect_if.slave      bus
`ifdef ALIEN_HIT_CNT_EN
   ,
   output logic [7:0]             hit_count
`endif
);

   localparam int PITCH  = SHAPE_W + SHAPE_SPACE;
   localparam int K_W    = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
   localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
   localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   localparam logic [K_W-1:0]    K_LAST    = K_W'(NUM_ALIENS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HIT_HOLD - 1);
   localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HIT,
      COOL
   } state_t;

   state_t                state;
   logic [K_W-1:0]        k;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [COOL_W-1:0]     cool_cnt;
   logic [9:0]            px_q;
   logic [9:0]            py_q;
   logic [9:0]            rx_q;
   logic [9:0]            ry_q;
   logic [NUM_ALIENS-1:0] alive_q;

   logic                  in_play;
   logic [10:0]           col_left;
   logic [10:0]           x_ext;
   logic [10:0]           y_ext;
   logic [10:0]           top;
   logic                  col_alive;
   logic [NUM_ALIENS-1:0] col_onehot;
   logic                  match;

   assign in_play = !(bus.curr_state inside {3'd0, 3'd5, 3'd6});

   // Column k maps to bit NUM_ALIENS-1-k; widening to 11 bits keeps right/bottom bounds from wrapping.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      col_alive  = 1'b0;
      col_onehot = '0;
      for (int i = 0; i < NUM_ALIENS; i++) begin
         if (K_W'(NUM_ALIENS - 1 - i) == k) begin
            col_alive     = alive_q[i];
            col_onehot[i] = 1'b1;
         end
      end
      col_left = {1'b0, rx_q} + 11'(k) * 11'(PITCH);
      x_ext    = {1'b0, px_q};
      y_ext    = {1'b0, py_q};
      top      = {1'b0, ry_q};
      match    = col_alive
               && (x_ext >= col_left) && (x_ext < col_left + 11'(SHAPE_W))
               && (y_ext >= top)      && (y_ext < top + 11'(SHAPE_H));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset || !in_play) begin
         state         <= IDLE;
         bus.hit       <= '0;
         bus.proj_kill <= 1'b0;
         bus.busy      <= 1'b0;
         k             <= '0;
         hold_cnt      <= '0;
         cool_cnt      <= '0;
`ifdef ALIEN_HIT_CNT_EN
         hit_count     <= 8'd0;
`endif
         // NOTE: the latched position/row registers are deliberately not reset; IDLE reloads them before any scan reads them.
      end else begin
         case (state)
            IDLE: begin
               if (bus.frame_tick && bus.proj_active) begin
                  px_q     <= bus.proj_x;
                  py_q     <= bus.proj_y;
                  rx_q     <= bus.row_x;
                  ry_q     <= bus.row_y;
                  alive_q  <= bus.row_alive;
                  k        <= '0;
                  state    <= SCAN;
                  bus.busy <= 1'b1;
               end
            end

            SCAN: begin
               if (match) begin
                  bus.hit       <= col_onehot;
                  bus.proj_kill <= 1'b1;
                  hold_cnt      <= HOLD_LOAD;
                  state         <= HIT;
`ifdef ALIEN_HIT_CNT_EN
                  if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`endif
               end else if (k == K_LAST) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  k <= k + K_W'(1);
               end
            end

            HIT: begin
               bus.proj_kill <= 1'b0;
               if (hold_cnt == '0) begin
                  bus.hit <= '0;
                  if (COOLDOWN == 0) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state    <= COOL;
                     cool_cnt <= COOL_LOAD;
                  end
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end

            COOL: begin
               if (cool_cnt == '0) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  cool_cnt <= cool_cnt - COOL_W'(1);
               end
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alien_hit_detect.sv
// Scoreboard bench for alien_hit_detect: a geometry model predicts each frame's outcome,
// the observed per-frame outcome is popped against it. Build with ALIEN_HIT_CNT_EN to cover hit_count.
module tb_alien_hit_detect;
   localparam int HIT_HOLD = 2;
   localparam int COOLDOWN = 4;
   localparam int WINDOW   = 20;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

`ifdef ALIEN_HIT_CNT_EN
   logic [7:0] hit_count;
`endif

   alien_hit_detect_if #(.NUM_ALIENS(7)) bus ();

   alien_hit_detect dut (
      .Clk      (clk),
      .Reset    (reset),
      .bus      (bus)
`ifdef ALIEN_HIT_CNT_EN
      ,
      .hit_count(hit_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int hit;
      int hit_cycle;
      int kill_count;
      int kill_cycle;
      int hit_len;
      int idle_cycle;
      int late_busy;
   } outcome_t;

   outcome_t expq[$];

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference geometry: first live column whose sprite box contains the projectile, else -1.
   function automatic int model_col(input int px, input int py, input int rx, input int ry,
                                    input logic [6:0] alive);
      for (int c = 0; c < 7; c++) begin
         int left;
         left = rx + c * 30;
         if (alive[6-c] && px >= left && px < left + 21 && py >= ry && py < ry + 16) return c;
      end
      return -1;
   endfunction

   task automatic push_expect(input int px, input int py, input int rx, input int ry,
                              input logic [6:0] alive);
      outcome_t e;
      int c;
      c = model_col(px, py, rx, ry, alive);
      e.late_busy = 0;
      if (c >= 0) begin
         e.hit        = 1 << (6 - c);
         e.hit_cycle  = 2 + c;
         e.kill_count = 1;
         e.kill_cycle = 2 + c;
         e.hit_len    = HIT_HOLD;
         e.idle_cycle = 2 + c + HIT_HOLD + COOLDOWN;
      end else begin
         e.hit        = 0;
         e.hit_cycle  = -1;
         e.kill_count = 0;
         e.kill_cycle = -1;
         e.hit_len    = 0;
         e.idle_cycle = 8;
      end
      expq.push_back(e);
   endtask

   // Called at posedge+1; frame_tick is high in cycle 0 of the frame.
   task automatic run_frame(input string tag, input int px, input int py, input int rx, input int ry,
                            input logic [6:0] alive, input bit drop_active, input bit retick);
      outcome_t o;
      outcome_t e;
      push_expect(px, py, rx, ry, alive);
      bus.proj_x     = 10'(px);
      bus.proj_y     = 10'(py);
      bus.row_x      = 10'(rx);
      bus.row_y      = 10'(ry);
      bus.row_alive  = alive;
      bus.frame_tick = 1'b1;
      o = '{hit: 0, hit_cycle: -1, kill_count: 0, kill_cycle: -1, hit_len: 0, idle_cycle: -1, late_busy: 0};
      for (int c = 0; c < WINDOW; c++) begin
         @(negedge clk);
         if (bus.hit != 7'd0) begin
            if (o.hit_cycle < 0) begin
               o.hit_cycle = c;
               o.hit       = int'(bus.hit);
            end
            o.hit_len++;
         end
         if (bus.proj_kill === 1'b1) begin
            o.kill_count++;
            if (o.kill_cycle < 0) o.kill_cycle = c;
         end
         if (o.idle_cycle >= 0 && bus.busy !== 1'b0) o.late_busy = 1;
         if (c >= 1 && o.idle_cycle < 0 && bus.busy === 1'b0) o.idle_cycle = c;
         next_cycle();
         if (c == 0) begin
            bus.frame_tick = 1'b0;
            if (drop_active) bus.proj_active = 1'b0;
         end
         if (retick && c == 5) bus.frame_tick = 1'b1;
         if (retick && c == 6) bus.frame_tick = 1'b0;
      end
      bus.proj_active = 1'b1;
      e = expq.pop_front();
      check({tag, ".hit"},        o.hit,        e.hit);
      check({tag, ".hit_cycle"},  o.hit_cycle,  e.hit_cycle);
      check({tag, ".kill_count"}, o.kill_count, e.kill_count);
      check({tag, ".kill_cycle"}, o.kill_cycle, e.kill_cycle);
      check({tag, ".hit_len"},    o.hit_len,    e.hit_len);
      check({tag, ".idle_cycle"}, o.idle_cycle, e.idle_cycle);
      check({tag, ".late_busy"},  o.late_busy,  e.late_busy);
   endtask

   initial begin
      int seen;
      reset           = 1'b1;
      bus.frame_tick  = 1'b0;
      bus.curr_state  = 3'd1;
      bus.proj_active = 1'b1;
      bus.proj_x      = 10'd0;
      bus.proj_y      = 10'd0;
      bus.row_x       = 10'd100;
      bus.row_y       = 10'd50;
      bus.row_alive   = 7'h7F;
      repeat (3) next_cycle();
      @(negedge clk);
      check("reset.hit",  bus.hit,       7'd0);
      check("reset.kill", bus.proj_kill, 1'b0);
      check("reset.busy", bus.busy,      1'b0);
`ifdef ALIEN_HIT_CNT_EN
      check("reset.hit_count", hit_count, 8'd0);
`endif
      next_cycle();
      reset = 1'b0;
      next_cycle();

      run_frame("t1_col2",     165, 55, 100, 50, 7'h7F, 1'b0, 1'b0);
`ifdef ALIEN_HIT_CNT_EN
      check("t1.hit_count", hit_count, 8'd1);
`endif
      run_frame("t2_gap",      125, 55, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("t3_dead",     165, 55, 100, 50, 7'b1101111, 1'b0, 1'b0);
      run_frame("t3_corner",   100, 50, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("t4_bottom",   165, 65, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("t4_below",    165, 66, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("t4_right",    120, 55, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("t4_past",     121, 55, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("last_col",    290, 60, 100, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("no_wrap",    1020, 55, 1010, 50, 7'h7F, 1'b0, 1'b0);
      run_frame("drop_active", 165, 55, 100, 50, 7'h7F, 1'b1, 1'b0);
      run_frame("t6_retick",   165, 55, 100, 50, 7'h7F, 1'b0, 1'b1);

      // frame_tick while no projectile is active must not start a scan.
      bus.proj_active = 1'b0;
      bus.frame_tick  = 1'b1;
      next_cycle();
      bus.frame_tick = 1'b0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) seen++;
         next_cycle();
      end
      check("inactive_tick.busy_cycles", seen, 0);
      bus.proj_active = 1'b1;

      // Reset asserted in cycle 4 of the test-1 frame.
      bus.proj_x     = 10'd165;
      bus.proj_y     = 10'd55;
      bus.frame_tick = 1'b1;
      next_cycle();
      bus.frame_tick = 1'b0;
      repeat (3) next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("rst_abort.pre_hit", bus.hit, 7'b0010000);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("rst_abort.hit",  bus.hit,  7'd0);
      check("rst_abort.busy", bus.busy, 1'b0);
      check("rst_abort.kill", bus.proj_kill, 1'b0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         @(negedge clk);
         if (bus.hit != 7'd0 || bus.proj_kill !== 1'b0) seen++;
      end
      check("rst_abort.no_later_hit", seen, 0);
      next_cycle();

      // Leaving play mid-scan aborts to IDLE on the next edge.
      bus.frame_tick = 1'b1;
      next_cycle();
      bus.frame_tick = 1'b0;
      @(negedge clk);
      check("state5.scan_busy", bus.busy, 1'b1);
      next_cycle();
      bus.curr_state = 3'd5;
      next_cycle();
      @(negedge clk);
      check("state5.busy", bus.busy, 1'b0);
      check("state5.hit",  bus.hit,  7'd0);
      bus.curr_state = 3'd1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         @(negedge clk);
         if (bus.hit != 7'd0 || bus.busy !== 1'b0) seen++;
      end
      check("state5.no_resume", seen, 0);
      next_cycle();

`ifdef ALIEN_HIT_CNT_EN
      bus.curr_state = 3'd0;
      next_cycle();
      @(negedge clk);
      check("cnt.clear_not_in_play", hit_count, 8'd0);
      next_cycle();
      bus.curr_state = 3'd1;
      for (int n = 0; n < 260; n++) begin
         bus.frame_tick = 1'b1;
         next_cycle();
         bus.frame_tick = 1'b0;
         repeat (11) next_cycle();
      end
      @(negedge clk);
      check("cnt.saturate", hit_count, 8'd255);
      next_cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
